// File: rtl/inf_nec_decoder_pkg.sv
// Shared definitions for the NEC infrared decoder: FSM states, frame layout
// and default pulse-width windows in 50 MHz sys_clk cycles.
package inf_nec_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD_LOW,
    ST_LEAD_HIGH,
    ST_DATA,
    ST_RPT
  } nec_state_t;

  localparam int NEC_LEAD_LOW_MIN  = 400000;
  localparam int NEC_LEAD_LOW_MAX  = 490000;
  localparam int NEC_LEAD_HIGH_MIN = 200000;
  localparam int NEC_LEAD_HIGH_MAX = 250000;
  localparam int NEC_RPT_HIGH_MIN  = 100000;
  localparam int NEC_RPT_HIGH_MAX  = 125000;
  localparam int NEC_BIT_SHORT_MIN = 20000;
  localparam int NEC_BIT_SHORT_MAX = 35000;
  localparam int NEC_BIT_LONG_MIN  = 80000;
  localparam int NEC_BIT_LONG_MAX  = 90000;
  localparam int NEC_CNT_W         = 19;

  localparam int NEC_FRAME_W  = 32;
  localparam int NEC_ADDR_LSB   = 0;
  localparam int NEC_ADDR_N_LSB = 8;
  localparam int NEC_CMD_LSB    = 16;
  localparam int NEC_CMD_N_LSB  = 24;

endpackage

// File: rtl/inf_edge_sync.sv
// Two-flop synchronizer for the active-low IR line plus a third register
// that turns level changes into single-cycle rise/fall pulses.
module inf_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic inf_p0;
  logic inf_p1;
  logic inf_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inf_p0 <= 1'b1;
      inf_p1 <= 1'b1;
      inf_p2 <= 1'b1;
    end else begin
      // p0/p1: metastability filter; p2: previous synchronized level
      inf_p0 <= din;
      inf_p1 <= inf_p0;
      inf_p2 <= inf_p1;
    end
  end

  assign rise =  inf_p1 & ~inf_p2;
  assign fall = ~inf_p1 &  inf_p2;

endmodule

// File: rtl/inf_nec_decoder.sv
// NEC IR frame decoder: measures every mark/space with one saturating counter,
// validates the address/command complements and flags repeat codes.
module inf_nec_decoder
  import inf_nec_decoder_pkg::*;
#(
  parameter int LEAD_LOW_MIN  = NEC_LEAD_LOW_MIN,
  parameter int LEAD_LOW_MAX  = NEC_LEAD_LOW_MAX,
  parameter int LEAD_HIGH_MIN = NEC_LEAD_HIGH_MIN,
  parameter int LEAD_HIGH_MAX = NEC_LEAD_HIGH_MAX,
  parameter int RPT_HIGH_MIN  = NEC_RPT_HIGH_MIN,
  parameter int RPT_HIGH_MAX  = NEC_RPT_HIGH_MAX,
  parameter int BIT_SHORT_MIN = NEC_BIT_SHORT_MIN,
  parameter int BIT_SHORT_MAX = NEC_BIT_SHORT_MAX,
  parameter int BIT_LONG_MIN  = NEC_BIT_LONG_MIN,
  parameter int BIT_LONG_MAX  = NEC_BIT_LONG_MAX,
  parameter int CNT_W         = NEC_CNT_W
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        inf_in,
  output logic        repeat_en,
  output logic [19:0] data_out
);

  localparam logic [CNT_W-1:0] LL_MIN  = CNT_W'(LEAD_LOW_MIN);
  localparam logic [CNT_W-1:0] LL_MAX  = CNT_W'(LEAD_LOW_MAX);
  localparam logic [CNT_W-1:0] LH_MIN  = CNT_W'(LEAD_HIGH_MIN);
  localparam logic [CNT_W-1:0] LH_MAX  = CNT_W'(LEAD_HIGH_MAX);
  localparam logic [CNT_W-1:0] RH_MIN  = CNT_W'(RPT_HIGH_MIN);
  localparam logic [CNT_W-1:0] RH_MAX  = CNT_W'(RPT_HIGH_MAX);
  localparam logic [CNT_W-1:0] BS_MIN  = CNT_W'(BIT_SHORT_MIN);
  localparam logic [CNT_W-1:0] BS_MAX  = CNT_W'(BIT_SHORT_MAX);
  localparam logic [CNT_W-1:0] BL_MIN  = CNT_W'(BIT_LONG_MIN);
  localparam logic [CNT_W-1:0] BL_MAX  = CNT_W'(BIT_LONG_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [4:0]       LAST_BIT = 5'(NEC_FRAME_W - 1);

  function automatic logic in_win(input logic [CNT_W-1:0] v,
                                  input logic [CNT_W-1:0] lo,
                                  input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  logic                   rise;
  logic                   fall;
  nec_state_t             state;
  logic [CNT_W-1:0]       cnt;
  logic [4:0]             bit_idx;
  logic                   in_space;
  logic                   in_stop;
  logic                   valid_seen;
  logic [NEC_FRAME_W-1:0] frame;
  logic                   frame_ok;

  inf_edge_sync u_edge_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .din   (inf_in),
    .rise  (rise),
    .fall  (fall)
  );

  assign frame_ok = (frame[NEC_ADDR_N_LSB +: 8] == ~frame[NEC_ADDR_LSB +: 8]) &&
                    (frame[NEC_CMD_N_LSB  +: 8] == ~frame[NEC_CMD_LSB  +: 8]);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      in_space   <= 1'b0;
      in_stop    <= 1'b0;
      valid_seen <= 1'b0;
      frame      <= '0;
      repeat_en  <= 1'b0;
      data_out   <= '0;
    end else begin
      // Every edge restarts the measurement; timeouts below also clear it.
      if (rise || fall)
        cnt <= '0;
      else if (state != ST_IDLE && cnt != CNT_MAX)
        cnt <= cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (fall)
            state <= ST_LEAD_LOW;
        end

        ST_LEAD_LOW: begin
          if (rise) begin
            state <= in_win(cnt, LL_MIN, LL_MAX) ? ST_LEAD_HIGH : ST_IDLE;
          end else if (cnt > LL_MAX) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        end

        ST_LEAD_HIGH: begin
          if (fall) begin
            if (in_win(cnt, LH_MIN, LH_MAX)) begin
              state    <= ST_DATA;
              bit_idx  <= '0;
              in_space <= 1'b0;
              in_stop  <= 1'b0;
            end else if (in_win(cnt, RH_MIN, RH_MAX)) begin
              state     <= ST_RPT;
              repeat_en <= valid_seen;
            end else begin
              state <= ST_IDLE;
            end
          end else if (cnt > LH_MAX) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        end

        ST_DATA: begin
          if (!in_space) begin
            if (rise) begin
              if (in_stop) begin
                // Stop burst finished: commit only a self-consistent frame.
                if (frame_ok)
                  data_out <= {12'h000, frame[NEC_CMD_LSB +: 8]};
                valid_seen <= valid_seen | frame_ok;
                state      <= ST_IDLE;
              end else if (in_win(cnt, BS_MIN, BS_MAX)) begin
                in_space <= 1'b1;
              end else begin
                state <= ST_IDLE;
              end
            end else if (cnt > BS_MAX) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end
          end else begin
            if (fall) begin
              if (in_win(cnt, BS_MIN, BS_MAX) || in_win(cnt, BL_MIN, BL_MAX)) begin
                frame[bit_idx] <= in_win(cnt, BL_MIN, BL_MAX);
                in_space       <= 1'b0;
                if (bit_idx == LAST_BIT)
                  in_stop <= 1'b1;
                else
                  bit_idx <= bit_idx + 1'b1;
              end else begin
                state <= ST_IDLE;
              end
            end else if (cnt > BL_MAX) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end
          end
        end

        ST_RPT: begin
          if (rise) begin
            repeat_en <= 1'b0;
            state     <= ST_IDLE;
          end else if (cnt > BS_MAX) begin
            repeat_en <= 1'b0;
            state     <= ST_IDLE;
            cnt       <= '0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inf_nec_decoder.sv
// Randomized directed bench for inf_nec_decoder with windows scaled by 1/1000
// so full NEC frames fit in a short simulation.
module tb_inf_nec_decoder;

  localparam int LL_MIN = 400, LL_MAX = 490;
  localparam int LH_MIN = 200, LH_MAX = 250;
  localparam int RH_MIN = 100, RH_MAX = 125;
  localparam int BS_MIN = 20,  BS_MAX = 35;
  localparam int BL_MIN = 80,  BL_MAX = 90;

  // Nominal widths centred in each window; jitter of +/-2 keeps them inside.
  localparam int W_LEAD_LOW  = 450;
  localparam int W_LEAD_HIGH = 225;
  localparam int W_RPT_HIGH  = 112;
  localparam int W_SHORT     = 28;
  localparam int W_LONG      = 85;
  localparam int W_GAP       = 300;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        inf_in    = 1'b1;
  logic        repeat_en;
  logic [19:0] data_out;

  int n_cmp = 0;
  int n_bad = 0;
  int rpt_total = 0;

  logic [19:0] exp_data   = 20'h0;
  logic        valid_seen = 1'b0;

  inf_nec_decoder #(
    .LEAD_LOW_MIN  (LL_MIN), .LEAD_LOW_MAX  (LL_MAX),
    .LEAD_HIGH_MIN (LH_MIN), .LEAD_HIGH_MAX (LH_MAX),
    .RPT_HIGH_MIN  (RH_MIN), .RPT_HIGH_MAX  (RH_MAX),
    .BIT_SHORT_MIN (BS_MIN), .BIT_SHORT_MAX (BS_MAX),
    .BIT_LONG_MIN  (BL_MIN), .BIT_LONG_MAX  (BL_MAX),
    .CNT_W         (19)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .inf_in    (inf_in),
    .repeat_en (repeat_en),
    .data_out  (data_out)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk)
    if (repeat_en === 1'b1) rpt_total <= rpt_total + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int jit(input int nom);
    return nom - 2 + int'($urandom_range(0, 4));
  endfunction

  task automatic drive(input logic lvl, input int n);
    #1 inf_in = lvl;
    repeat (n) @(posedge sys_clk);
  endtask

  // Sends one frame and updates the reference: only complement-consistent
  // frames change the expected output and arm repeat reporting.
  task automatic send_frame(input string tag, input logic [7:0] a, input logic [7:0] na,
                            input logic [7:0] c, input logic [7:0] nc);
    logic [31:0] w;
    int r0;
    w  = {nc, c, na, a};
    r0 = rpt_total;
    drive(1'b0, jit(W_LEAD_LOW));
    drive(1'b1, jit(W_LEAD_HIGH));
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, jit(W_SHORT));
      drive(1'b1, w[i] ? jit(W_LONG) : jit(W_SHORT));
    end
    drive(1'b0, jit(W_SHORT));
    drive(1'b1, W_GAP);
    if (na == ~a && nc == ~c) begin
      exp_data   = {12'h000, c};
      valid_seen = 1'b1;
    end
    #1;
    check({tag, "_data"}, data_out, exp_data);
    check({tag, "_norpt"}, rpt_total - r0, 0);
  endtask

  task automatic send_repeat(input string tag);
    int n;
    int r0;
    n = jit(W_SHORT);
    drive(1'b0, jit(W_LEAD_LOW));
    drive(1'b1, jit(W_RPT_HIGH));
    r0 = rpt_total;
    drive(1'b0, n / 2);
    #1 check({tag, "_mid"}, repeat_en, valid_seen);
    drive(1'b0, n - n / 2);
    drive(1'b1, 10);
    #1 check({tag, "_after"}, repeat_en, 0);
    check({tag, "_len"}, rpt_total - r0, valid_seen ? n : 0);
    drive(1'b1, W_GAP);
    #1 check({tag, "_data"}, data_out, exp_data);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] c;
    logic [7:0] na;
    logic [7:0] nc;
    logic [31:0] w;

    repeat (5) @(posedge sys_clk);
    #1;
    check("rst_data", data_out, 20'h0);
    check("rst_rpt", repeat_en, 0);
    sys_rst_n = 1'b1;
    drive(1'b1, 20);

    send_repeat("rpt_before_frame");
    send_frame("frame_24", 8'h12, 8'hED, 8'h24, 8'hDB);
    send_repeat("rpt1");
    drive(1'b1, W_GAP);
    send_repeat("rpt2");

    send_frame("bad_cmpl", 8'h12, 8'hED, 8'h24, 8'hDA);
    send_frame("frame_5a", 8'h12, 8'hED, 8'h5A, 8'hA5);

    // Leader far too short, then leader that never ends in time.
    drive(1'b0, 150);
    drive(1'b1, W_GAP);
    #1 check("short_lead", data_out, exp_data);
    drive(1'b0, 600);
    drive(1'b1, W_GAP);
    #1 check("long_lead", data_out, exp_data);
    send_frame("after_abort", 8'h01, 8'hFE, 8'h3C, 8'hC3);

    // Reset in the middle of the data bits.
    w = 32'h96_69_E1_1E;
    drive(1'b0, jit(W_LEAD_LOW));
    drive(1'b1, jit(W_LEAD_HIGH));
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, jit(W_SHORT));
      drive(1'b1, w[i] ? jit(W_LONG) : jit(W_SHORT));
    end
    drive(1'b0, 10);
    #1 sys_rst_n = 1'b0;
    #1;
    check("midrst_data", data_out, 20'h0);
    check("midrst_rpt", repeat_en, 0);
    exp_data   = 20'h0;
    valid_seen = 1'b0;
    inf_in     = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    drive(1'b1, 50);
    send_repeat("rpt_after_rst");
    send_frame("after_rst", 8'hE1, 8'h1E, 8'h69, 8'h96);
    send_repeat("rpt_after_rst_frame");

    for (int k = 0; k < 5; k++) begin
      a  = 8'($urandom);
      c  = 8'($urandom);
      na = ~a;
      nc = ~c;
      case ($urandom_range(0, 2))
        0: na = na ^ (8'h01 << $urandom_range(0, 7));
        1: nc = nc ^ (8'h01 << $urandom_range(0, 7));
        default: ;
      endcase
      send_frame("rand_frame", a, na, c, nc);
      if ($urandom_range(0, 1) == 1) send_repeat("rand_rpt");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
